// File: rtl/mem_write_checker_pkg.sv
// Shared types for the memory-write checker: FSM state encoding and table entry width.
// MEM_WRITE_CHECKER_ADDR_CHECK_EN selects whether the address is stored and compared.
package mem_write_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_PASS  = 2'd2,
    S_FAIL  = 2'd3
  } state_e;

`ifdef MEM_WRITE_CHECKER_ADDR_CHECK_EN
  localparam bit ADDR_CHECK_EN = 1'b1;
`else
  localparam bit ADDR_CHECK_EN = 1'b0;
`endif

  // Stored bits per expected entry; the address field exists only with address checking.
  function automatic int unsigned entry_width(int unsigned addr_w, int unsigned data_w);
    return data_w + (ADDR_CHECK_EN ? addr_w : 0);
  endfunction

endpackage

// File: rtl/mem_write_checker_exp_table.sv
// Expected-store table: DEPTH entries, one write port, one asynchronous read port, no reset.
// Address storage exists only when MEM_WRITE_CHECKER_ADDR_CHECK_EN is defined.
module exp_table
  import mem_write_checker_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned ENTRY_W = entry_width(ADDR_W, DATA_W);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] wentry;

`ifdef MEM_WRITE_CHECKER_ADDR_CHECK_EN
  assign wentry         = {waddr, wdata};
  assign {raddr, rdata} = mem_q[ridx];
`else
  logic unused_waddr;
  assign wentry       = wdata;
  assign rdata        = mem_q[ridx];
  assign raddr        = '0;
  assign unused_waddr = ^waddr;
`endif

  // Contents deliberately survive reset so a check can be re-armed without reloading.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wentry;
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the store bus against an ordered expected-store table; registered pass/fail/timeout.
// Define MEM_WRITE_CHECKER_ADDR_CHECK_EN to require the address to match as well as the data.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4096,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W:0]    num_exp,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [IDX_W-1:0]  err_idx,
  output logic [DATA_W-1:0] got_data,
  output logic [IDX_W:0]    wr_count
);

  localparam int unsigned    WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [IDX_W:0]  N_MAX   = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]  CNT_ONE = (IDX_W + 1)'(1);

  state_e              state_q;
  logic [IDX_W:0]      n_q;
  logic [IDX_W:0]      wr_count_q;
  logic [WD_W-1:0]     wd_q;
  logic                busy_q, done_q, pass_q, fail_q, timeout_q;
  logic [IDX_W-1:0]    err_idx_q;
  logic [DATA_W-1:0]   got_data_q;

  logic                tbl_we;
  logic [ADDR_W-1:0]   tbl_addr;
  logic [DATA_W-1:0]   tbl_data;
  logic                match;
  logic [IDX_W:0]      wr_next;

  assign tbl_we  = exp_we && (state_q != S_CHECK);
  assign wr_next = wr_count_q + CNT_ONE;

  exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_exp_table (
    .clk   (clk),
    .we    (tbl_we),
    .widx  (exp_idx),
    .waddr (exp_addr),
    .wdata (exp_data),
    .ridx  (wr_count_q[IDX_W-1:0]),
    .raddr (tbl_addr),
    .rdata (tbl_data)
  );

  // An X/Z bit makes match unknown; the if below then takes the mismatch branch.
`ifdef MEM_WRITE_CHECKER_ADDR_CHECK_EN
  assign match = (adr == tbl_addr) && (writedata == tbl_data);
`else
  logic unused_addr;
  assign match       = (writedata == tbl_data);
  assign unused_addr = ^{adr, tbl_addr};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      wr_count_q <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_idx_q  <= '0;
      got_data_q <= '0;
    end else begin
      case (state_q)
        S_CHECK: begin
          if (n_q == '0) begin
            state_q <= S_PASS;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (memwrite) begin
            if (match) begin
              wr_count_q <= wr_next;
              wd_q       <= '0;
              if (wr_next == n_q) begin
                state_q <= S_PASS;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
              end
            end else begin
              state_q    <= S_FAIL;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              fail_q     <= 1'b1;
              err_idx_q  <= wr_count_q[IDX_W-1:0];
              got_data_q <= writedata;
            end
          end else if (wd_q == WD_LAST) begin
            // This edge takes the watchdog to TIMEOUT-1.
            state_q   <= S_FAIL;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            fail_q    <= 1'b1;
            timeout_q <= 1'b1;
            err_idx_q <= wr_count_q[IDX_W-1:0];
          end else begin
            wd_q <= wd_q + WD_ONE;
          end
        end
        default: begin
          if (start) begin
            state_q    <= S_CHECK;
            n_q        <= (num_exp > N_MAX) ? N_MAX : num_exp;
            wr_count_q <= '0;
            wd_q       <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_idx_q  <= '0;
            got_data_q <= '0;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign err_idx  = err_idx_q;
  assign got_data = got_data_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: directed scenarios plus randomized store streams
// scored against a store-by-store reference model.
module tb_mem_write_checker;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int TMO   = 16;
  localparam int BTMO  = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [IW:0]   num_exp = '0;
  logic          exp_we = 1'b0;
  logic [IW-1:0] exp_idx = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          memwrite = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] writedata = '0;

  logic          busy, done, pass, fail, timeout;
  logic [IW-1:0] err_idx;
  logic [DW-1:0] got_data;
  logic [IW:0]   wr_count;
  logic          b_busy, b_done, b_pass, b_fail, b_timeout;
  logic [IW-1:0] b_err_idx;
  logic [DW-1:0] b_got_data;
  logic [IW:0]   b_wr_count;

  logic [4:0] flags, b_flags;
  assign flags   = {busy, done, pass, fail, timeout};
  assign b_flags = {b_busy, b_done, b_pass, b_fail, b_timeout};

  mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_exp(num_exp), .exp_we(exp_we),
    .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .err_idx(err_idx), .got_data(got_data), .wr_count(wr_count)
  );

  mem_write_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(BTMO)) dut_big (
    .clk(clk), .reset(reset), .start(start), .num_exp(num_exp), .exp_we(exp_we),
    .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail(b_fail), .timeout(b_timeout), .err_idx(b_err_idx), .got_data(b_got_data),
    .wr_count(b_wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference table and scenario description.
  logic [AW-1:0] ref_a [DEPTH];
  logic [DW-1:0] ref_d [DEPTH];
  int            n_req, nst;
  int            gap [16];
  logic [AW-1:0] sa [16];
  logic [DW-1:0] sd [16];

  // Model prediction.
  bit            e_pass, e_to;
  int            e_err, e_wr, e_cyc;
  logic [DW-1:0] e_got;

  // Observations taken by drive_scenario.
  logic [4:0]    o_pre, o_flags, o_hold;
  logic [IW-1:0] o_err;
  logic [DW-1:0] o_got;
  logic [IW:0]   o_wr, o_hold_wr;

  logic          sch_mw [256];
  logic [AW-1:0] sch_a [256];
  logic [DW-1:0] sch_d [256];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_we   = 1'b1;
    exp_idx  = IW'(idx);
    exp_addr = a;
    exp_data = d;
    tick();
    exp_we   = 1'b0;
    ref_a[idx] = a;
    ref_d[idx] = d;
  endtask

  function automatic bit store_ok(input int k);
`ifdef MEM_WRITE_CHECKER_ADDR_CHECK_EN
    return (sd[k] == ref_d[k]) && (sa[k] == ref_a[k]);
`else
    return sd[k] == ref_d[k];
`endif
  endfunction

  // Walks the stores in order: each gap of tmo-1 idle cycles or more expires the watchdog.
  task automatic predict(input int tmo);
    int n, t, k;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    e_pass = 0; e_to = 0; e_err = 0; e_got = '0; e_wr = 0; e_cyc = 0;
    t = 0; k = 0;
    if (n == 0) begin
      e_pass = 1; e_cyc = 1;
      return;
    end
    while (1'b1) begin
      if (k >= nst || gap[k] >= tmo - 1) begin
        e_to = 1; e_err = k; e_wr = k; e_cyc = t + tmo - 1;
        return;
      end
      t += gap[k] + 1;
      if (!store_ok(k)) begin
        e_err = k; e_got = sd[k]; e_wr = k; e_cyc = t;
        return;
      end
      k++;
      if (k == n) begin
        e_pass = 1; e_wr = n; e_cyc = t;
        return;
      end
    end
  endtask

  // Arms the checker, replays the store schedule and samples around the predicted verdict.
  task automatic drive_scenario(input bit junk);
    int t;
    predict(TMO);
    for (int c = 0; c < 256; c++) begin
      sch_mw[c] = 1'b0; sch_a[c] = '0; sch_d[c] = '0;
    end
    t = 0;
    for (int k = 0; k < nst; k++) begin
      t += gap[k] + 1;
      sch_mw[t] = 1'b1; sch_a[t] = sa[k]; sch_d[t] = sd[k];
    end
    num_exp = n_req[IW:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= e_cyc + 3; c++) begin
      memwrite  = sch_mw[c];
      adr       = sch_a[c];
      writedata = sch_d[c];
      if (junk && c <= e_cyc) begin
        exp_we   = 1'($urandom_range(1));
        exp_idx  = IW'($urandom_range(DEPTH - 1));
        exp_addr = $urandom;
        exp_data = $urandom;
        start    = 1'($urandom_range(1));
      end else begin
        exp_we = 1'b0;
        start  = 1'b0;
      end
      tick();
      if (c == e_cyc - 1) o_pre = flags;
      if (c == e_cyc) begin
        o_flags = flags; o_err = err_idx; o_got = got_data; o_wr = wr_count;
      end
      if (c == e_cyc + 3) begin
        o_hold = flags; o_hold_wr = wr_count;
      end
    end
    memwrite = 1'b0; exp_we = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    tick(); tick();
    checks++;
    if ({flags, err_idx, got_data, wr_count} !== '0) begin
      failures++;
      $display("FAIL reset_hold: got flags=%b wr=%0d want all zero", flags, wr_count);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({flags, err_idx, got_data, wr_count, b_flags} !== '0) begin
      failures++;
      $display("FAIL reset_release: got flags=%b b_flags=%b want all zero", flags, b_flags);
    end
  endtask

  task automatic test_first_store;
    load_entry(0, 32'h54, 32'hFFFF7F02);
    num_exp = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      memwrite  = (c == 20);
      adr       = 32'h54;
      writedata = 32'hFFFF7F02;
      tick();
      if (c == 15) begin
        checks++;
        if (flags !== 5'b01011 || err_idx !== 3'd0) begin
          failures++;
          $display("FAIL first_store_short_tmo: got flags=%b err=%0d want 01011 err=0",
                   flags, err_idx);
        end
      end
      if (c == 19) begin
        checks++;
        if (b_flags !== 5'b10000) begin
          failures++;
          $display("FAIL first_store_wait: got flags=%b want 10000", b_flags);
        end
      end
      if (c == 20) begin
        checks++;
        if (b_flags !== 5'b01100 || b_wr_count !== 4'd1) begin
          failures++;
          $display("FAIL first_store_pass: got flags=%b wr=%0d want 01100 wr=1",
                   b_flags, b_wr_count);
        end
      end
    end
    memwrite = 1'b0;
  endtask

  task automatic test_mismatch;
    for (int i = 0; i < 3; i++) load_entry(i, $urandom, $urandom | 32'h100);
    n_req = 3; nst = 3;
    gap[0] = 1; gap[1] = 0; gap[2] = 2;
    for (int k = 0; k < 3; k++) begin
      sa[k] = ref_a[k]; sd[k] = ref_d[k];
    end
    sd[2] = 32'h7;
    drive_scenario(1'b0);
    checks++;
    if (o_flags !== 5'b01010 || o_err !== 3'd2 || o_got !== 32'h7 || o_wr !== 4'd2) begin
      failures++;
      $display("FAIL mismatch: got flags=%b err=%0d data=%h wr=%0d want 01010 2 00000007 2",
               o_flags, o_err, o_got, o_wr);
    end
    checks++;
    if (o_hold !== 5'b01010 || o_hold_wr !== 4'd2) begin
      failures++;
      $display("FAIL mismatch_sticky: got flags=%b wr=%0d want 01010 wr=2", o_hold, o_hold_wr);
    end
  endtask

  task automatic test_timeout;
    n_req = 2; nst = 1; gap[0] = 0;
    sa[0] = ref_a[0]; sd[0] = ref_d[0];
    drive_scenario(1'b0);
    checks++;
    if (o_pre !== 5'b10000) begin
      failures++;
      $display("FAIL timeout_early: got flags=%b want 10000", o_pre);
    end
    checks++;
    if (o_flags !== 5'b01011 || o_err !== 3'd1 || o_wr !== 4'd1) begin
      failures++;
      $display("FAIL timeout: got flags=%b err=%0d wr=%0d want 01011 err=1 wr=1",
               o_flags, o_err, o_wr);
    end
  endtask

  task automatic test_timeout_race;
    n_req = 2; nst = 2; gap[0] = 0; gap[1] = TMO - 2;
    for (int k = 0; k < 2; k++) begin
      sa[k] = ref_a[k]; sd[k] = ref_d[k];
    end
    drive_scenario(1'b0);
    checks++;
    if (o_flags !== 5'b01100 || o_wr !== 4'd2) begin
      failures++;
      $display("FAIL timeout_race: got flags=%b wr=%0d want 01100 wr=2", o_flags, o_wr);
    end
  endtask

  task automatic test_reset_mid_check;
    for (int i = 0; i < 3; i++) load_entry(i, $urandom, $urandom);
    num_exp = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    memwrite = 1'b1; adr = ref_a[0]; writedata = ref_d[0];
    tick();
    memwrite = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({flags, err_idx, got_data, wr_count, b_flags, b_err_idx, b_got_data, b_wr_count} !== '0)
    begin
      failures++;
      $display("FAIL reset_mid_check: got flags=%b wr=%0d b_flags=%b want all zero",
               flags, wr_count, b_flags);
    end
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    n_req = 3; nst = 3;
    for (int k = 0; k < 3; k++) begin
      gap[k] = $urandom_range(3); sa[k] = ref_a[k]; sd[k] = ref_d[k];
    end
    drive_scenario(1'b0);
    checks++;
    if (o_flags !== 5'b01100 || o_wr !== 4'd3) begin
      failures++;
      $display("FAIL table_retained: got flags=%b wr=%0d want 01100 wr=3", o_flags, o_wr);
    end
  endtask

  task automatic test_zero_and_clamp;
    n_req = 0; nst = 0;
    drive_scenario(1'b0);
    checks++;
    if (o_flags !== 5'b01100 || o_wr !== 4'd0) begin
      failures++;
      $display("FAIL zero_count: got flags=%b wr=%0d want 01100 wr=0", o_flags, o_wr);
    end
    for (int i = 0; i < DEPTH; i++) load_entry(i, $urandom, $urandom);
    n_req = DEPTH + 3; nst = DEPTH + 1;
    for (int k = 0; k < nst; k++) begin
      gap[k] = $urandom_range(2);
      sa[k] = (k < DEPTH) ? ref_a[k] : $urandom;
      sd[k] = (k < DEPTH) ? ref_d[k] : $urandom;
    end
    drive_scenario(1'b0);
    checks++;
    if (o_flags !== 5'b01100 || o_wr !== 4'd8) begin
      failures++;
      $display("FAIL clamp_depth: got flags=%b wr=%0d want 01100 wr=8", o_flags, o_wr);
    end
  endtask

  task automatic test_addr;
    logic [4:0]  want_flags;
    logic [IW:0] want_wr;
    load_entry(0, 32'h1000, 32'hCAFE0001);
    n_req = 1; nst = 1; gap[0] = 1;
    sa[0] = 32'h1004; sd[0] = 32'hCAFE0001;
`ifdef MEM_WRITE_CHECKER_ADDR_CHECK_EN
    want_flags = 5'b01010; want_wr = 4'd0;
`else
    want_flags = 5'b01100; want_wr = 4'd1;
`endif
    drive_scenario(1'b0);
    checks++;
    if (o_flags !== want_flags || o_wr !== want_wr) begin
      failures++;
      $display("FAIL wrong_addr: got flags=%b wr=%0d want %b wr=%0d",
               o_flags, o_wr, want_flags, want_wr);
    end
  endtask

  task automatic test_random;
    int r, nn;
    logic [4:0] want;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(3) == 0) begin
        for (int i = 0; i < DEPTH; i++) load_entry(i, $urandom, $urandom);
      end
      n_req = $urandom_range(DEPTH + 4);
      nn = (n_req > DEPTH) ? DEPTH : n_req;
      nst = nn + $urandom_range(1);
      for (int k = 0; k < nst; k++) begin
        r = $urandom_range(19);
        gap[k] = (r < 15) ? r % 4 : r - 1;
        sa[k] = (k < DEPTH) ? ref_a[k] : $urandom;
        sd[k] = (k < DEPTH) ? ref_d[k] : $urandom;
        if ($urandom_range(7) == 0) begin
          if ($urandom_range(1) == 0) sd[k] = sd[k] ^ (32'h1 << $urandom_range(31));
          else sa[k] = sa[k] ^ (32'h1 << $urandom_range(31));
        end
      end
      drive_scenario(1'b1);
      want = {1'b0, 1'b1, e_pass, !e_pass, e_to};
      checks++;
      if (o_flags !== want) begin
        failures++;
        $display("FAIL rand%0d_flags: got %b want %b", it, o_flags, want);
      end
      checks++;
      if (o_err !== e_err[IW-1:0] || o_got !== e_got || o_wr !== e_wr[IW:0]) begin
        failures++;
        $display("FAIL rand%0d_fields: got err=%0d data=%h wr=%0d want err=%0d data=%h wr=%0d",
                 it, o_err, o_got, o_wr, e_err, e_got, e_wr);
      end
      if (e_cyc > 1) begin
        checks++;
        if (o_pre !== 5'b10000) begin
          failures++;
          $display("FAIL rand%0d_early: got %b want 10000", it, o_pre);
        end
      end
      checks++;
      if (o_hold !== want || o_hold_wr !== e_wr[IW:0]) begin
        failures++;
        $display("FAIL rand%0d_sticky: got %b wr=%0d want %b wr=%0d",
                 it, o_hold, o_hold_wr, want, e_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_store();
    test_mismatch();
    test_timeout();
    test_timeout_race();
    test_reset_mid_check();
    test_zero_and_clamp();
    test_addr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
